// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, control FSM states and datapath select codes.
package rv32i_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'd0, PC_IMM = 2'd1, PC_JALR = 2'd2
   } pc_src_t;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2
   } wb_sel_t;

   typedef enum logic [1:0] {
      TC_NONE = 2'd0, TC_ILLEGAL = 2'd1, TC_TIMEOUT = 2'd2, TC_ECALL = 2'd3
   } trap_cause_t;

   localparam int CL_R      = 0;
   localparam int CL_IMM    = 1;
   localparam int CL_LOAD   = 2;
   localparam int CL_STORE  = 3;
   localparam int CL_BRANCH = 4;
   localparam int CL_LUI    = 5;
   localparam int CL_AUIPC  = 6;
   localparam int CL_JAL    = 7;
   localparam int CL_JALR   = 8;
   localparam int CL_SYS    = 9;
   localparam int NCLS      = 10;

   typedef logic [NCLS-1:0] opclass_t;

endpackage

// File: rtl/rv32i_multicycle_ctrl_if.sv
// Shared instruction/data memory port between control FSM and memory.
interface rv32i_multicycle_ctrl_if;
   logic mem_req;
   logic mem_we;
   logic addr_sel;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output addr_sel,
                   input mem_ready);
   modport slave  (input mem_req, input mem_we, input addr_sel,
                   output mem_ready);
endinterface

// File: rtl/rv32i_opclass_dec.sv
// Opcode to one-hot instruction class, plus legality flag.
module rv32i_opclass_dec
   import rv32i_pkg::*;
(
   input  logic [6:0] opcode,
   output opclass_t   cls,
   output logic       legal
);

   always_comb begin
      cls   = '0;
      legal = 1'b1;
      unique case (opcode)
         OP_R:      cls[CL_R]      = 1'b1;
         OP_IMM:    cls[CL_IMM]    = 1'b1;
         OP_LOAD:   cls[CL_LOAD]   = 1'b1;
         OP_STORE:  cls[CL_STORE]  = 1'b1;
         OP_BRANCH: cls[CL_BRANCH] = 1'b1;
         OP_LUI:    cls[CL_LUI]    = 1'b1;
         OP_AUIPC:  cls[CL_AUIPC]  = 1'b1;
         OP_JAL:    cls[CL_JAL]    = 1'b1;
         OP_JALR:   cls[CL_JALR]   = 1'b1;
         OP_SYSTEM: cls[CL_SYS]    = 1'b1;
         default:   legal          = 1'b0;
      endcase
   end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I main control FSM with shared memory port,
// retired-instruction counter and sticky trap.
module rv32i_multicycle_ctrl
   import rv32i_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int INSTRET_W   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              opcode,
   input  logic                    branch_taken,
   rv32i_multicycle_ctrl_if.master mem,
   output logic                    ir_we,
   output logic                    pc_we,
   output logic [1:0]              pc_src,
   output logic                    alu_src_a,
   output logic                    alu_src_b,
   output logic                    reg_we,
   output logic [1:0]              wb_sel,
   output logic                    trap,
   output logic [1:0]              trap_cause,
   output logic [INSTRET_W-1:0]    instret
);

   state_t      state, state_n;
   opclass_t    cls_q, dec_cls;
   logic        dec_legal;
   logic [7:0]  tcnt;
   logic        tmo;
   trap_cause_t cause_q, cause_n;
   logic        req, we, asel, retire;

   rv32i_opclass_dec u_dec (
      .opcode (opcode),
      .cls    (dec_cls),
      .legal  (dec_legal)
   );

   // limit hit only when this wait cycle also lacks ready
   assign tmo = (tcnt == 8'(MEM_TIMEOUT - 1)) && !mem.mem_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      cause_n = TC_NONE;
      unique case (state)
         S_FETCH: begin
            if (mem.mem_ready) state_n = S_DECODE;
            else if (tmo) begin
               state_n = S_TRAP;
               cause_n = TC_TIMEOUT;
            end
         end
         S_DECODE: begin
            if (!dec_legal) begin
               state_n = S_TRAP;
               cause_n = TC_ILLEGAL;
            end else if (dec_cls[CL_SYS]) begin
               state_n = S_TRAP;
               cause_n = TC_ECALL;
            end else state_n = S_EXEC;
         end
         S_EXEC: begin
            unique case (1'b1)
               cls_q[CL_BRANCH]: state_n = S_FETCH;
               cls_q[CL_LOAD],
               cls_q[CL_STORE]:  state_n = S_MEM;
               cls_q[CL_R], cls_q[CL_IMM], cls_q[CL_LUI],
               cls_q[CL_AUIPC], cls_q[CL_JAL],
               cls_q[CL_JALR]:   state_n = S_WB;
               cls_q[CL_SYS]: begin
                  state_n = S_TRAP;
                  cause_n = TC_ECALL;
               end
               default: begin
                  state_n = S_TRAP;
                  cause_n = TC_ILLEGAL;
               end
            endcase
         end
         S_MEM: begin
            if (mem.mem_ready)
               state_n = cls_q[CL_STORE] ? S_FETCH : S_WB;
            else if (tmo) begin
               state_n = S_TRAP;
               cause_n = TC_TIMEOUT;
            end
         end
         S_WB:    state_n = S_FETCH;
         default: state_n = S_TRAP;
      endcase
   end

   always_comb begin
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = PC_PLUS4;
      asel      = 1'b0;
      req       = 1'b0;
      we        = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      reg_we    = 1'b0;
      wb_sel    = WB_ALU;
      retire    = 1'b0;
      unique case (state)
         S_FETCH: begin
            req   = 1'b1;
            ir_we = mem.mem_ready;
         end
         S_EXEC: begin
            alu_src_a = cls_q[CL_AUIPC] | cls_q[CL_JAL] | cls_q[CL_BRANCH];
            alu_src_b = !(cls_q[CL_R] | cls_q[CL_BRANCH]);
            if (cls_q[CL_BRANCH]) begin
               pc_we  = 1'b1;
               pc_src = branch_taken ? PC_IMM : PC_PLUS4;
               retire = 1'b1;
            end
         end
         S_MEM: begin
            req  = 1'b1;
            asel = 1'b1;
            we   = cls_q[CL_STORE];
            if (cls_q[CL_STORE] && mem.mem_ready) begin
               pc_we  = 1'b1;
               retire = 1'b1;
            end
         end
         S_WB: begin
            reg_we = 1'b1;
            pc_we  = 1'b1;
            retire = 1'b1;
            if (cls_q[CL_LOAD]) wb_sel = WB_MEM;
            else if (cls_q[CL_JAL] | cls_q[CL_JALR]) wb_sel = WB_PC4;
            if (cls_q[CL_JAL]) pc_src = PC_IMM;
            else if (cls_q[CL_JALR]) pc_src = PC_JALR;
         end
         default: ;
      endcase
      // an abandoned access must not leave any strobe high
      if (rst) begin
         ir_we  = 1'b0;
         pc_we  = 1'b0;
         req    = 1'b0;
         we     = 1'b0;
         reg_we = 1'b0;
         retire = 1'b0;
      end
   end

   assign mem.mem_req  = req;
   assign mem.mem_we   = we;
   assign mem.addr_sel = asel;
   assign trap_cause   = cause_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cls_q   <= '0;
         tcnt    <= '0;
         trap    <= 1'b0;
         cause_q <= TC_NONE;
         instret <= '0;
      end else begin
         if (state == S_DECODE) cls_q <= dec_cls;
         if (state_n != state || !req) tcnt <= '0;
         else tcnt <= tcnt + 8'd1;
         if (state_n == S_TRAP && state != S_TRAP) begin
            trap    <= 1'b1;
            cause_q <= cause_n;
         end
         if (retire) instret <= instret + INSTRET_W'(1);
      end
   end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Directed-vector bench for the multi-cycle RV32I control FSM.
module tb_rv32i_multicycle_ctrl;

   localparam logic [6:0] ADDI = 7'h13;
   localparam logic [6:0] LW   = 7'h03;
   localparam logic [6:0] SW   = 7'h23;
   localparam logic [6:0] BEQ  = 7'h63;
   localparam logic [6:0] JALR = 7'h67;
   localparam logic [6:0] SYS  = 7'h73;
   localparam logic [6:0] BAD  = 7'h7F;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  opcode = ADDI;
   logic        branch_taken = 1'b0;
   logic        ir_we, pc_we, alu_src_a, alu_src_b, reg_we, trap;
   logic [1:0]  pc_src, wb_sel, trap_cause;
   logic [31:0] instret;

   int n_cmp = 0;
   int n_bad = 0;

   rv32i_multicycle_ctrl_if mif ();

   rv32i_multicycle_ctrl #(
      .MEM_TIMEOUT (16),
      .INSTRET_W   (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .branch_taken (branch_taken),
      .mem          (mif),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .pc_src       (pc_src),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .reg_we       (reg_we),
      .wb_sel       (wb_sel),
      .trap         (trap),
      .trap_cause   (trap_cause),
      .instret      (instret)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // {ir_we,pc_we,mem_req,mem_we,reg_we,addr_sel,alu_a,alu_b,pc_src,wb_sel}
   function automatic logic [11:0] outs();
      return {ir_we, pc_we, mif.mem_req, mif.mem_we, reg_we, mif.addr_sel,
              alu_src_a, alu_src_b, pc_src, wb_sel};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string tag, input logic rdy,
                      input logic [11:0] exp);
      mif.mem_ready = rdy;
      #1;
      chk(tag, 32'(outs()), 32'(exp));
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mif.mem_ready = 1'b1;
      #1;
      chk("rst_strobes", 32'(outs()), 32'd0);
      step();
      rst = 1'b0;
   endtask

   localparam logic [11:0] O_F   = 12'b1_0_1_0_0_0_0_0_00_00;
   localparam logic [11:0] O_FW  = 12'b0_0_1_0_0_0_0_0_00_00;
   localparam logic [11:0] O_IDL = 12'b0;
   localparam logic [11:0] O_EI  = 12'b0_0_0_0_0_0_0_1_00_00;

   initial begin
      mif.mem_ready = 1'b1;
      step();
      do_reset();
      chk("rst_instret", instret, 32'd0);
      chk("rst_trap", {30'd0, trap_cause}, 32'd0);

      opcode = ADDI;
      cyc("addi_f", 1'b1, O_F);
      cyc("addi_d", 1'b1, O_IDL);
      cyc("addi_e", 1'b1, O_EI);
      cyc("addi_w", 1'b1, 12'b0_1_0_0_1_0_0_0_00_00);
      chk("addi_instret", instret, 32'd1);

      opcode = LW;
      cyc("lw_f", 1'b1, O_F);
      cyc("lw_d", 1'b1, O_IDL);
      cyc("lw_e", 1'b1, O_EI);
      for (int i = 0; i < 3; i++)
         cyc("lw_mwait", 1'b0, 12'b0_0_1_0_0_1_0_0_00_00);
      cyc("lw_m", 1'b1, 12'b0_0_1_0_0_1_0_0_00_00);
      cyc("lw_w", 1'b1, 12'b0_1_0_0_1_0_0_0_00_01);
      chk("lw_instret", instret, 32'd2);

      opcode = BEQ;
      branch_taken = 1'b1;
      cyc("beqt_f", 1'b1, O_F);
      cyc("beqt_d", 1'b1, O_IDL);
      cyc("beqt_e", 1'b1, 12'b0_1_0_0_0_0_1_0_01_00);
      branch_taken = 1'b0;
      cyc("beqn_f", 1'b1, O_F);
      cyc("beqn_d", 1'b1, O_IDL);
      cyc("beqn_e", 1'b1, 12'b0_1_0_0_0_0_1_0_00_00);
      chk("beq_instret", instret, 32'd4);

      opcode = JALR;
      cyc("jalr_f", 1'b1, O_F);
      cyc("jalr_d", 1'b1, O_IDL);
      cyc("jalr_e", 1'b1, O_EI);
      cyc("jalr_w", 1'b1, 12'b0_1_0_0_1_0_0_0_10_10);

      opcode = SW;
      cyc("sw_f", 1'b1, O_F);
      cyc("sw_d", 1'b1, O_IDL);
      cyc("sw_e", 1'b1, O_EI);
      cyc("sw_m", 1'b1, 12'b0_1_1_1_0_1_0_0_00_00);
      chk("sw_instret", instret, 32'd6);

      opcode = BAD;
      cyc("ill_f", 1'b1, O_F);
      cyc("ill_d", 1'b1, O_IDL);
      chk("ill_trap", {31'd0, trap}, 32'd1);
      chk("ill_cause", {30'd0, trap_cause}, 32'd1);
      for (int i = 0; i < 20; i++)
         cyc("ill_quiet", 1'b1, O_IDL);
      chk("ill_cause_held", {30'd0, trap_cause}, 32'd1);
      chk("ill_instret", instret, 32'd6);
      do_reset();
      chk("ill_rst_trap", {31'd0, trap}, 32'd0);
      chk("ill_rst_instret", instret, 32'd0);

      opcode = SYS;
      cyc("ecall_f", 1'b1, O_F);
      cyc("ecall_d", 1'b1, O_IDL);
      chk("ecall_cause", {30'd0, trap_cause}, 32'd3);
      do_reset();

      opcode = ADDI;
      for (int i = 0; i < 16; i++) begin
         chk("tmo_notrap", {31'd0, trap}, 32'd0);
         cyc("tmo_fwait", 1'b0, O_FW);
      end
      chk("tmo_trap", {31'd0, trap}, 32'd1);
      chk("tmo_cause", {30'd0, trap_cause}, 32'd2);
      cyc("tmo_quiet", 1'b0, O_IDL);
      do_reset();

      opcode = LW;
      for (int i = 0; i < 15; i++)
         cyc("late_fwait", 1'b0, O_FW);
      cyc("late_f", 1'b1, O_F);
      chk("late_notrap", {31'd0, trap}, 32'd0);
      cyc("late_d", 1'b0, O_IDL);
      cyc("late_e", 1'b0, O_EI);
      cyc("late_mwait", 1'b0, 12'b0_0_1_0_0_1_0_0_00_00);
      rst = 1'b1;
      #1;
      chk("midrst_req", {31'd0, mif.mem_req}, 32'd0);
      step();
      rst = 1'b0;
      cyc("midrst_f", 1'b1, O_F);
      chk("midrst_instret", instret, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
